tile_scratchpad: RTL
====================

Name: tile_scratchpad

Overview:
- Parametrised, banked operand/result scratchpad for the tiled vector MAC array.
- Serves strided LANES-wide A-vector and W-vector fetches over valid/ready handshakes.
- Absorbs lane-masked result write-back.
- Streams a result region out word-by-word for test readout.
- Sits between the host preload path and the vector unit, replacing the fixed-geometry operand RAM.

Parameters:
- DATA_WIDTH, 16: element width in bits.
- LANES, 4: elements per vector (vector unit width).
- DEPTH, 1024: words of storage; power of two.
- ADDR_WIDTH, 10: log2(DEPTH).
- STRIDE_WIDTH, 10: width of per-request element stride.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_we  in  1  host preload write strobe.
- init_addr  in  ADDR_WIDTH  preload word address.
- init_data  in  DATA_WIDTH  preload word.
- a_req_valid  in  1  A fetch request.
- a_req_ready  out  1  A fetch accepted when high with valid.
- a_addr  in  ADDR_WIDTH  base address of lane 0.
- a_stride  in  STRIDE_WIDTH  address step between lanes (e.g. COL_M for column fetch).
- a_valid  out  1  one-cycle pulse, a_data valid.
- a_data  out  LANES*DATA_WIDTH  lane i in bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- w_req_valid, w_req_ready, w_addr, w_stride, w_valid, w_data: same as the A channel, independent.
- res_valid  in  1  result write request.
- res_ready  out  1  result write accepted.
- res_addr  in  ADDR_WIDTH  address of lane 0; lane i written at res_addr+i.
- res_mask  in  LANES  per-lane write enable.
- res_data  in  LANES*DATA_WIDTH  result vector, same lane packing.
- dump_start  in  1  start readout.
- dump_base  in  ADDR_WIDTH  first readout address.
- dump_len  in  ADDR_WIDTH+1  number of words, 0..DEPTH.
- dump_valid  out  1  dump_data valid this cycle.
- dump_data  out  DATA_WIDTH  readout word.
- dump_busy  out  1  readout in progress.
- dump_done  out  1  one-cycle pulse after the last word.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - Fetch pipelines emptied.
  - Dump FSM to IDLE; counters 0.
  - Memory contents are not reset.
  - Reset asserted mid-dump or mid-fetch aborts it: no dump_done, no a_valid/w_valid.
- Fetch pipeline, per channel:
  - Handshake accepts on req_valid & req_ready.
  - Stage 1 registers lane addresses (addr + i*stride) mod DEPTH; wrap via truncation to ADDR_WIDTH.
  - Stage 2 registers the data. a_valid asserts exactly 2 cycles after the accepting edge.
  - Fully pipelined: back-to-back requests give back-to-back valids.
- req_ready = ~dump_busy. Fetches are held off only during readout.
- Result write:
  - res_ready = ~dump_busy.
  - On accept, each masked lane i writes (res_addr+i) mod DEPTH on that edge.
  - res_mask=0 is a legal no-op handshake.
- Write priority on the same address in the same cycle: res lane > init_we.
- Read/write collision: a fetch whose stage-2 read hits an address written on the same edge returns the old data. New data is visible to reads sampled from the next edge onward.
- Strides: stride 0 is legal and replicates one word to all lanes.
- Dump FSM:
  - IDLE: dump_start & dump_len!=0 -> RUN; ptr=dump_base; cnt=dump_len.
  - IDLE: dump_start & dump_len==0 -> DONE with no dump_valid.
  - RUN: each cycle output fifo[ptr] registered (dump_valid=1), ptr=ptr+1 mod DEPTH, cnt-1. After the last word -> DONE.
  - DONE: dump_done=1 for one cycle -> IDLE.
  - dump_busy=1 in RUN and DONE.
  - dump_start while busy is ignored.
- Dump ordering: dump_start asserts dump_busy on the next edge. In-flight fetches already accepted still complete.
- The dump reads a coherent snapshot because writes and fetch acceptance are blocked while busy. init_we is not blocked; host responsibility.

Decomposition:
- Shared package/header `config_sys`: DATA_WIDTH, LANES, DEPTH, ADDR_WIDTH, STRIDE_WIDTH defaults, lane-slice macros, C_ADDR (default dump base).
- One sub-module, sp_fetch_port: address generator plus 2-stage read pipeline, instantiated for A and W.
- Dump FSM and write logic stay in the top level.

Test Plan:
- Preload fifo[k]=k for k=0..1023; A request addr=0, stride=16 -> 2 cycles later a_valid=1, a_data lanes={0,16,32,48}; W request addr=5, stride=1 same cycle -> w_data={5,6,7,8}.
- 8 back-to-back A requests addr=n, stride=1 -> 8 consecutive a_valid pulses starting at cycle 2, lane0=n in order; stride 0 at addr=9 -> {9,9,9,9}.
- Wrap: A addr=1022, stride=1 -> {1022,1023,0,1}; res_addr=1023, mask=4'b1111, data {A,B,C,D} -> fifo[1023]=A, fifo[0..2]=B,C,D.
- Mask and collision: res write addr=512 mask=4'b0101 data {1,2,3,4} -> fifo[512]=1, fifo[514]=3, 513/515 unchanged; fetch of 512 reading on the write edge returns old value 512, next fetch returns 1.
- Dump base=512 len=4 -> dump_valid for 4 cycles with data 1,513,3,515, then dump_done one cycle; a_req_ready and res_ready low throughout busy; dump_len=0 -> dump_done only.
- Assert rst_n=0 on the 2nd dump cycle -> all outputs 0 immediately, no dump_done; after release a fetch of addr 512 returns 1 (memory retained).

Source files
------------

// File: rtl/tile_scratchpad_pkg.sv
// Shared configuration for the tile scratchpad: default geometry, default dump base
// and the readout state type.
package tile_scratchpad_pkg;

  localparam int SP_DATA_WIDTH   = 16;
  localparam int SP_LANES        = 4;
  localparam int SP_DEPTH        = 1024;
  localparam int SP_ADDR_WIDTH   = 10;
  localparam int SP_STRIDE_WIDTH = 10;

  // Default base for readout of the result region.
  localparam logic [SP_ADDR_WIDTH-1:0] C_ADDR = '0;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_RUN,
    DUMP_DONE
  } dump_state_t;

endpackage

// File: rtl/sp_fetch_port.sv
// Strided vector fetch port: stage 1 latches the per-lane addresses, stage 2 latches
// the words read from the shared storage.
module sp_fetch_port
  import tile_scratchpad_pkg::*;
#(
  parameter int DATA_WIDTH   = SP_DATA_WIDTH,
  parameter int LANES        = SP_LANES,
  parameter int ADDR_WIDTH   = SP_ADDR_WIDTH,
  parameter int STRIDE_WIDTH = SP_STRIDE_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [STRIDE_WIDTH-1:0]          stride,
  output logic [LANES*ADDR_WIDTH-1:0]      rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0]      rd_data,
  output logic                             valid,
  output logic [LANES*DATA_WIDTH-1:0]      data
);

  logic                        accept;
  logic                        s1_valid;
  logic [LANES*ADDR_WIDTH-1:0] s1_addr;
  logic [LANES*ADDR_WIDTH-1:0] lane_addr;

  assign accept  = req_valid & req_ready;
  assign rd_addr = s1_addr;

  // Lane addresses wrap modulo DEPTH simply by keeping only ADDR_WIDTH bits.
  always_comb begin
    lane_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
        addr + ADDR_WIDTH'(stride) * ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      valid    <= 1'b0;
      data     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= lane_addr;
      end
      valid <= s1_valid;
      if (s1_valid) begin
        data <= rd_data;
      end
    end
  end

endmodule

// File: rtl/tile_scratchpad.sv
// Banked operand/result scratchpad: two strided fetch ports, lane-masked result
// write-back, host preload and a word-serial readout of a result region.
module tile_scratchpad
  import tile_scratchpad_pkg::*;
#(
  parameter int DATA_WIDTH   = SP_DATA_WIDTH,
  parameter int LANES        = SP_LANES,
  parameter int DEPTH        = SP_DEPTH,
  parameter int ADDR_WIDTH   = SP_ADDR_WIDTH,
  parameter int STRIDE_WIDTH = SP_STRIDE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_we,
  input  logic [ADDR_WIDTH-1:0]       init_addr,
  input  logic [DATA_WIDTH-1:0]       init_data,
  input  logic                        a_req_valid,
  output logic                        a_req_ready,
  input  logic [ADDR_WIDTH-1:0]       a_addr,
  input  logic [STRIDE_WIDTH-1:0]     a_stride,
  output logic                        a_valid,
  output logic [LANES*DATA_WIDTH-1:0] a_data,
  input  logic                        w_req_valid,
  output logic                        w_req_ready,
  input  logic [ADDR_WIDTH-1:0]       w_addr,
  input  logic [STRIDE_WIDTH-1:0]     w_stride,
  output logic                        w_valid,
  output logic [LANES*DATA_WIDTH-1:0] w_data,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [ADDR_WIDTH-1:0]       res_addr,
  input  logic [LANES-1:0]            res_mask,
  input  logic [LANES*DATA_WIDTH-1:0] res_data,
  input  logic                        dump_start,
  input  logic [ADDR_WIDTH-1:0]       dump_base,
  input  logic [ADDR_WIDTH:0]         dump_len,
  output logic                        dump_valid,
  output logic [DATA_WIDTH-1:0]       dump_data,
  output logic                        dump_busy,
  output logic                        dump_done
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LANES*ADDR_WIDTH-1:0] a_rd_addr, w_rd_addr;
  logic [LANES*DATA_WIDTH-1:0] a_rd_data, w_rd_data;
  logic                        res_fire;

  dump_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] dump_ptr, ptr_next;
  logic [ADDR_WIDTH:0]   dump_cnt, cnt_next;
  logic                  dump_valid_next;
  logic [DATA_WIDTH-1:0] dump_data_next;

  // Holding off fetches and result writes during readout keeps the dump a coherent snapshot.
  assign dump_busy   = (state != DUMP_IDLE);
  assign dump_done   = (state == DUMP_DONE);
  assign a_req_ready = ~dump_busy;
  assign w_req_ready = ~dump_busy;
  assign res_ready   = ~dump_busy;
  assign res_fire    = res_valid & res_ready;

  sp_fetch_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LANES       (LANES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRIDE_WIDTH(STRIDE_WIDTH)
  ) u_fetch_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(a_req_valid),
    .req_ready(a_req_ready),
    .addr     (a_addr),
    .stride   (a_stride),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .valid    (a_valid),
    .data     (a_data)
  );

  sp_fetch_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LANES       (LANES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STRIDE_WIDTH(STRIDE_WIDTH)
  ) u_fetch_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(w_req_valid),
    .req_ready(w_req_ready),
    .addr     (w_addr),
    .stride   (w_stride),
    .rd_addr  (w_rd_addr),
    .rd_data  (w_rd_data),
    .valid    (w_valid),
    .data     (w_data)
  );

  always_comb begin
    a_rd_data = '0;
    w_rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[a_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[w_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // Result lanes are written after the preload so they win on a shared address;
  // reads on the same edge still see the old word.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end
    if (res_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (res_mask[i]) begin
          mem[res_addr + ADDR_WIDTH'(i)] <= res_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // RUN keeps going until the count is exhausted, so dump_done lands the cycle after the last word.
  always_comb begin
    state_next      = state;
    ptr_next        = dump_ptr;
    cnt_next        = dump_cnt;
    dump_valid_next = 1'b0;
    dump_data_next  = dump_data;
    case (state)
      DUMP_IDLE: begin
        if (dump_start) begin
          ptr_next   = dump_base;
          cnt_next   = dump_len;
          state_next = (dump_len == '0) ? DUMP_DONE : DUMP_RUN;
        end
      end
      DUMP_RUN: begin
        if (dump_cnt != '0) begin
          dump_valid_next = 1'b1;
          dump_data_next  = mem[dump_ptr];
          ptr_next        = dump_ptr + 1'b1;
          cnt_next        = dump_cnt - 1'b1;
        end else begin
          state_next = DUMP_DONE;
        end
      end
      DUMP_DONE: begin
        state_next = DUMP_IDLE;
      end
      default: begin
        state_next = DUMP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DUMP_IDLE;
      dump_ptr   <= '0;
      dump_cnt   <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
    end else begin
      state      <= state_next;
      dump_ptr   <= ptr_next;
      dump_cnt   <= cnt_next;
      dump_valid <= dump_valid_next;
      dump_data  <= dump_data_next;
    end
  end

endmodule
